// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared types, constants and state index mapping for the ChaCha block sequencer
package chacha_pkg;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  typedef logic [31:0] chacha_word_t;
  typedef chacha_word_t [15:0] chacha_state_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} ctrl_state_t;

  // State word feeding a given quarter-round lane and row (a=0..d=3).
  // Diagonal rounds shift the column by the row number, wrapping mod 4.
  function automatic logic [3:0] qr_index(input logic [1:0] lane, input logic [1:0] row,
                                          input logic diag);
    logic [1:0] col;
    col = diag ? (lane + row) : lane;
    return {row, col};
  endfunction

endpackage

// File: rtl/chacha_quarter_round.sv
// rtl/chacha_quarter_round.sv - combinational ChaCha quarter-round on four words
module chacha_quarter_round #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] c_o,
  output logic [WIDTH-1:0] d_o
);

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int unsigned n);
    return (x << n) | (x >> (WIDTH - n));
  endfunction

  logic [WIDTH-1:0] a1, b1, c1, d1;

  assign a1  = a_i + b_i;
  assign d1  = rotl(d_i ^ a1, 16);
  assign c1  = c_i + d1;
  assign b1  = rotl(b_i ^ c1, 12);
  assign a_o = a1 + b1;
  assign d_o = rotl(d1 ^ a_o, 8);
  assign c_o = c1 + d_o;
  assign b_o = rotl(b1 ^ c_o, 7);

endmodule

// File: rtl/chacha_round.sv
// rtl/chacha_round.sv - one column or diagonal round built from four parallel quarter-rounds
module chacha_round
  import chacha_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  chacha_state_t state_i,
  input  logic          diag_i,
  output chacha_state_t state_o
);

  chacha_word_t qa_in [4];
  chacha_word_t qb_in [4];
  chacha_word_t qc_in [4];
  chacha_word_t qd_in [4];
  chacha_word_t qa_out[4];
  chacha_word_t qb_out[4];
  chacha_word_t qc_out[4];
  chacha_word_t qd_out[4];

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      qa_in[l] = state_i[qr_index(2'(l), 2'd0, diag_i)];
      qb_in[l] = state_i[qr_index(2'(l), 2'd1, diag_i)];
      qc_in[l] = state_i[qr_index(2'(l), 2'd2, diag_i)];
      qd_in[l] = state_i[qr_index(2'(l), 2'd3, diag_i)];
    end
  end

  for (genvar l = 0; l < 4; l++) begin : g_qr
    chacha_quarter_round #(.WIDTH(WIDTH)) u_qr (
      .a_i(qa_in[l]),
      .b_i(qb_in[l]),
      .c_i(qc_in[l]),
      .d_i(qd_in[l]),
      .a_o(qa_out[l]),
      .b_o(qb_out[l]),
      .c_o(qc_out[l]),
      .d_o(qd_out[l])
    );
  end

  // Every word is written by exactly one lane, so the default is fully overwritten.
  always_comb begin
    state_o = state_i;
    for (int l = 0; l < 4; l++) begin
      state_o[qr_index(2'(l), 2'd0, diag_i)] = qa_out[l];
      state_o[qr_index(2'(l), 2'd1, diag_i)] = qb_out[l];
      state_o[qr_index(2'(l), 2'd2, diag_i)] = qc_out[l];
      state_o[qr_index(2'(l), 2'd3, diag_i)] = qd_out[l];
    end
  end

endmodule

// File: rtl/chacha_block_ctrl.sv
// rtl/chacha_block_ctrl.sv - iterative ChaCha block sequencer: FSM, round counter, state and feed-forward
module chacha_block_ctrl
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20,
  parameter int WIDTH  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output logic         busy
);

  localparam int CNT_W = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
  chacha_state_t    init_q, init_d;
  chacha_state_t    work_q, work_d;
  chacha_state_t    ks_q, ks_d;
  chacha_state_t    req_state;
  chacha_state_t    round_out;

  always_comb begin
    req_state[0] = SIGMA0;
    req_state[1] = SIGMA1;
    req_state[2] = SIGMA2;
    req_state[3] = SIGMA3;
    for (int i = 0; i < 8; i++) req_state[4 + i] = key[32*i +: 32];
    req_state[12] = counter;
    for (int i = 0; i < 3; i++) req_state[13 + i] = nonce[32*i +: 32];
  end

  // Even counts are column rounds, odd counts diagonal rounds.
  chacha_round #(.WIDTH(WIDTH)) u_round (
    .state_i(work_q),
    .diag_i (round_cnt_q[0]),
    .state_o(round_out)
  );

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    init_d      = init_q;
    work_d      = work_q;
    ks_d        = ks_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          init_d      = req_state;
          work_d      = req_state;
          round_cnt_d = '0;
          state_d     = ROUND;
        end
      end
      ROUND: begin
        work_d = round_out;
        if (round_cnt_q == LAST_RND) begin
          for (int i = 0; i < 16; i++) ks_d[i] = round_out[i] + init_q[i];
          round_cnt_d = '0;
          state_d     = DONE;
        end else begin
          round_cnt_d = round_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_cnt_q <= '0;
      init_q      <= '0;
      work_q      <= '0;
      ks_q        <= '0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      init_q      <= init_d;
      work_q      <= work_d;
      ks_q        <= ks_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign keystream = ks_q;

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// tb/tb_chacha_block_ctrl.sv - self-checking bench for chacha_block_ctrl (ROUNDS 20 and 8 builds)
module tb_chacha_block_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [255:0] key;
  logic [31:0]  counter;
  logic [95:0]  nonce;
  logic [511:0] keystream;

  logic         in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [255:0] key8;
  logic [31:0]  counter8;
  logic [95:0]  nonce8;
  logic [511:0] keystream8;

  int checks = 0;
  int errors = 0;

  chacha_block_ctrl #(.ROUNDS(20), .WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .counter(counter), .nonce(nonce), .out_valid(out_valid),
    .out_ready(out_ready), .keystream(keystream), .busy(busy)
  );

  chacha_block_ctrl #(.ROUNDS(8), .WIDTH(32)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .key(key8), .counter(counter8), .nonce(nonce8), .out_valid(out_valid8),
    .out_ready(out_ready8), .keystream(keystream8), .busy(busy8)
  );

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // RFC 8439 style reference: double rounds over a word array, then feed-forward.
  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [31:0] c,
                                             input logic [95:0] n, input int rounds);
    logic [31:0] x[16];
    logic [31:0] s[16];
    logic [511:0] r;
    int qi[8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                     '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int dr = 0; dr < rounds / 2; dr++) begin
      for (int q = 0; q < 8; q++) begin
        int a, b, cc, d;
        a = qi[q][0]; b = qi[q][1]; cc = qi[q][2]; d = qi[q][3];
        x[a] = x[a] + x[b];   x[d] = rotl(x[d] ^ x[a], 16);
        x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
        x[a] = x[a] + x[b];   x[d] = rotl(x[d] ^ x[a], 8);
        x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [95:0] rand96();
    logic [95:0] r;
    for (int i = 0; i < 3; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n,
                        output logic [511:0] ks, output int lat);
    int w;
    w = 0;
    key = k; counter = c; nonce = n; in_valid = 1'b1;
    while (!in_ready && w < 100) begin tick(); w++; end
    tick();
    in_valid = 1'b0;
    key = ~k; counter = ~c; nonce = ~n;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    ks = keystream;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_req8(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n,
                         output logic [511:0] ks, output int lat);
    int w;
    w = 0;
    key8 = k; counter8 = c; nonce8 = n; in_valid8 = 1'b1;
    while (!in_ready8 && w < 100) begin tick(); w++; end
    tick();
    in_valid8 = 1'b0;
    key8 = rand256(); counter8 = $urandom; nonce8 = rand96();
    lat = 0;
    while (!out_valid8 && lat < 100) begin tick(); lat++; end
    ks = keystream8;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; key = '0; counter = '0; nonce = '0;
    in_valid8 = 0; out_ready8 = 0; key8 = '0; counter8 = '0; nonce8 = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (keystream !== 512'd0) begin errors++; $display("FAIL reset_keystream: got %h want 0", keystream); end
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8: got %b want 1", in_ready8); end
  endtask

  task automatic test_rfc_vector();
    logic [255:0] k;
    logic [511:0] ks, exp;
    int lat;
    for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
    do_req(k, 32'd1, {32'h00000000, 32'h4a000000, 32'h09000000}, ks, lat);
    exp = ref_block(k, 32'd1, {32'h00000000, 32'h4a000000, 32'h09000000}, 20);
    checks++; if (lat !== 20) begin errors++; $display("FAIL rfc_latency: got %0d want 20", lat); end
    checks++; if (ks[31:0] !== 32'he4e7f110) begin errors++; $display("FAIL rfc_w0: got %h want e4e7f110", ks[31:0]); end
    checks++; if (ks[63:32] !== 32'h15593bd1) begin errors++; $display("FAIL rfc_w1: got %h want 15593bd1", ks[63:32]); end
    checks++; if (ks[95:64] !== 32'h1fdd0f50) begin errors++; $display("FAIL rfc_w2: got %h want 1fdd0f50", ks[95:64]); end
    checks++; if (ks[127:96] !== 32'hc47120a3) begin errors++; $display("FAIL rfc_w3: got %h want c47120a3", ks[127:96]); end
    checks++; if (ks[511:480] !== 32'h4e3c50a2) begin errors++; $display("FAIL rfc_w15: got %h want 4e3c50a2", ks[511:480]); end
    checks++; if (ks !== exp) begin errors++; $display("FAIL rfc_block: got %h want %h", ks, exp); end
  endtask

  task automatic test_zero_input();
    logic [511:0] ks;
    int lat;
    do_req('0, '0, '0, ks, lat);
    checks++; if (ks[31:0] !== 32'hade0b876) begin errors++; $display("FAIL zero_w0: got %h want ade0b876", ks[31:0]); end
    checks++; if (ks[63:32] !== 32'h903df1a0) begin errors++; $display("FAIL zero_w1: got %h want 903df1a0", ks[63:32]); end
    checks++; if (ks !== ref_block('0, '0, '0, 20)) begin errors++; $display("FAIL zero_block: got %h", ks); end
  endtask

  task automatic test_backpressure();
    logic [255:0] k1, k2;
    logic [95:0]  n1, n2;
    logic [511:0] hold, ks2;
    int w;
    k1 = rand256(); n1 = rand96(); k2 = rand256(); n2 = rand96();
    key = k1; counter = 32'd7; nonce = n1; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    tick();
    key = k2; counter = 32'd8; nonce = n2;
    w = 0;
    while (!out_valid && w < 100) begin tick(); w++; end
    hold = keystream;
    checks++; if (hold !== ref_block(k1, 32'd7, n1, 20)) begin errors++; $display("FAIL bp_block1: got %h", hold); end
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++; if (keystream !== hold) begin errors++; $display("FAIL bp_stable[%0d]: got %h want %h", i, keystream, hold); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_post_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_post_busy: got %b want 0", busy); end
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_second_accept: busy got %b want 1", busy); end
    w = 0;
    while (!out_valid && w < 100) begin tick(); w++; end
    ks2 = keystream;
    checks++; if (w !== 20) begin errors++; $display("FAIL bp_second_latency: got %0d want 20", w); end
    checks++; if (ks2 !== ref_block(k2, 32'd8, n2, 20)) begin errors++; $display("FAIL bp_block2: got %h", ks2); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [255:0] k;
    logic [95:0]  n;
    logic [511:0] blk[2];
    int acc_t[2];
    int na, nb, cyc;
    k = rand256(); n = rand96();
    na = 0; nb = 0; cyc = 0;
    blk[0] = '0; blk[1] = '0; acc_t[0] = 0; acc_t[1] = 0;
    key = k; nonce = n; counter = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    while (nb < 2 && cyc < 120) begin
      if (in_valid && in_ready) begin acc_t[na] = cyc; na++; end
      if (out_valid && out_ready) begin blk[nb] = keystream; nb++; end
      tick();
      cyc++;
      if (na == 1) counter = 32'd2;
      if (na == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (nb !== 2) begin errors++; $display("FAIL b2b_blocks: got %0d want 2", nb); end
    checks++; if (acc_t[1] - acc_t[0] !== 22) begin errors++; $display("FAIL b2b_interval: got %0d want 22", acc_t[1] - acc_t[0]); end
    checks++; if (blk[0] !== ref_block(k, 32'd1, n, 20)) begin errors++; $display("FAIL b2b_block1: got %h", blk[0]); end
    checks++; if (blk[1] !== ref_block(k, 32'd2, n, 20)) begin errors++; $display("FAIL b2b_block2: got %h", blk[1]); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  c;
    logic [511:0] ks;
    int w, lat;
    k = rand256(); n = rand96(); c = $urandom;
    key = k; counter = c; nonce = n; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (keystream !== 512'd0) begin errors++; $display("FAIL mid_keystream: got %h want 0", keystream); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    k = rand256(); n = rand96(); c = $urandom;
    do_req(k, c, n, ks, lat);
    checks++; if (lat !== 20) begin errors++; $display("FAIL mid_fresh_latency: got %0d want 20", lat); end
    checks++; if (ks !== ref_block(k, c, n, 20)) begin errors++; $display("FAIL mid_fresh_block: got %h", ks); end
  endtask

  task automatic test_random20();
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  c;
    logic [511:0] ks;
    int lat;
    for (int i = 0; i < 6; i++) begin
      k = rand256(); n = rand96(); c = $urandom;
      do_req(k, c, n, ks, lat);
      checks++; if (lat !== 20) begin errors++; $display("FAIL rand20_latency[%0d]: got %0d want 20", i, lat); end
      checks++; if (ks !== ref_block(k, c, n, 20)) begin errors++; $display("FAIL rand20_block[%0d]: got %h", i, ks); end
    end
  endtask

  task automatic test_rounds8();
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  c;
    logic [511:0] ks;
    int lat;
    for (int i = 0; i < 100; i++) begin
      k = rand256(); n = rand96(); c = $urandom;
      do_req8(k, c, n, ks, lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL r8_latency[%0d]: got %0d want 8", i, lat); end
      checks++; if (ks !== ref_block(k, c, n, 8)) begin errors++; $display("FAIL r8_block[%0d]: got %h", i, ks); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rfc_vector();
    test_zero_input();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random20();
    test_rounds8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chacha_block_ctrl.md
Name: chacha_block_ctrl

Overview:
Iterative ChaCha20 block-function sequencer.
- Accepts key, block counter and nonce over a valid/ready handshake, then builds the 16-word initial state.
- Runs one column or diagonal round per clock through four parallel chacha_quarter_round instances, and finishes with the feed-forward addition.
- Presents the 512-bit keystream block on a valid/ready output port.
- Sits between the message-authentication/encryption front end and the existing quarter-round datapath.

Parameters:
- ROUNDS, 20: total rounds. Must be even and ≥2. 20 gives ChaCha20; 8 and 12 are legal for ChaCha8/12.
- WIDTH, 32: word width passed to chacha_quarter_round. Only 32 is supported.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request carries a valid key/counter/nonce.
- in_ready  out  1  block can accept a request.
- key  in  256  key. Word k = key[32k+31:32k], little-endian words as in RFC 8439.
- counter  in  32  block counter, state word 12.
- nonce  in  96  nonce. Word n = nonce[32n+31:32n], mapped to state words 13..15.
- out_valid  out  1  keystream block valid.
- out_ready  in  1  consumer accepts the block.
- keystream  out  512  output block. Word i = keystream[32i+31:32i].
- busy  out  1  high in ROUND and DONE.

Behaviour:
- Reset: asynchronous, active-low. Forces the following, regardless of in-flight work; the partial block is discarded and never emitted.
  - FSM = IDLE, round_cnt = 0.
  - in_ready = 1 after reset release; out_valid = 0, busy = 0.
  - keystream = 0, working and initial state registers = 0.
- Initial state:
  - Words 0..3: sigma = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
  - Words 4..11: key words 0..7.
  - Word 12: counter.
  - Words 13..15: nonce words 0..2.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch the initial state into both init_q and work_q, set round_cnt = 0, go to ROUND.
- ROUND:
  - in_ready = 0. Each cycle work_q <= round(work_q); round_cnt increments.
  - Even round_cnt: column round, quarter-rounds on (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
  - Odd round_cnt: diagonal round, quarter-rounds on (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  - On the cycle with round_cnt == ROUNDS-1: keystream <= round(work_q) + init_q, word-wise mod 2^32 with carries not crossing words. Go to DONE; round_cnt returns to 0.
- DONE:
  - out_valid = 1. keystream is stable and inputs are ignored.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
- Latency:
  - Accept edge at cycle 0; out_valid first high at cycle ROUNDS (20 for the default).
  - Minimum issue interval is ROUNDS+2 cycles with out_ready tied high.
- Request inputs may change freely after the accept edge; only the latched copy is used.
- Backpressure: out_valid holds indefinitely with keystream unchanged, and no new request is accepted while in DONE.
- The counter is not incremented internally. Multi-block sequencing is owned by the requester.
- in_valid asserted in ROUND/DONE is not accepted and is not lost: the requester holds it until in_ready.

Decomposition:
- Package chacha_pkg holds:
  - SIGMA0..3 constants.
  - typedef chacha_word_t (logic[31:0]) and chacha_state_t (array of 16 chacha_word_t).
  - typedef enum ctrl_state_t {IDLE, ROUND, DONE}.
- Sub-module chacha_round:
  - Combinational; inputs chacha_state_t and a diag select.
  - Instantiates four chacha_quarter_round and applies the column/diagonal index mapping.
- chacha_block_ctrl holds the FSM, round counter, state registers and feed-forward adder.

Test Plan:
- RFC 8439 §2.3.2 vector:
  - Stimulus: key bytes 00..1f (key word0 = 0x03020100), counter = 1, nonce words 0x09000000, 0x4a000000, 0x00000000.
  - Response: keystream words 0..3 = 0xe4e7f110, 0x15593bd1, 0x1fdd0f50, 0xc47120a3; word 15 = 0x4e3c50a2. out_valid rises exactly 20 cycles after the accept.
- Backpressure:
  - Stimulus: out_ready held low 50 cycles after out_valid, with in_valid held high and a second request presented.
  - Response: keystream stable, in_ready = 0, second request not accepted until the cycle after the out_ready handshake.
- Back-to-back:
  - Stimulus: two requests with counter 1 then 2, out_ready tied high.
  - Response: two blocks matching the golden model; the second accept occurs exactly 22 cycles after the first.
- Reset mid-operation:
  - Stimulus: rst_n pulsed low asynchronously at round_cnt = 7.
  - Response: immediately out_valid = 0, busy = 0, keystream = 0. After release in_ready = 1, and a fresh request produces the correct block.
- All-zero input:
  - Stimulus: key = 0, counter = 0, nonce = 0.
  - Response: keystream word0 = 0xade0b876, word1 = 0x903df1a0 (known ChaCha20 zero vector).
- ROUNDS = 8 build: checked against the C reference model over 100 random requests; out_valid 8 cycles after each accept.
